// File: rtl/capture_sequencer_if.sv
// rtl/capture_sequencer_if.sv - host/generator signal bundle for capture_sequencer
// forceTrigger exists only when CAPSEQ_FORCE_TRIG_EN is defined.
interface capture_sequencer_if #(
    parameter int SAMPLE_WIDTH = 16
);
    logic                    start;
    logic                    abort;
    logic [SAMPLE_WIDTH-1:0] sampleData;
    logic [SAMPLE_WIDTH-1:0] trigMask;
    logic [SAMPLE_WIDTH-1:0] trigValue;
    logic [31:0]             preTriggerSampleCountMax;
    logic                    write_enable;
    logic                    complete;
`ifdef CAPSEQ_FORCE_TRIG_EN
    logic                    forceTrigger;
`endif
    logic                    idle;
    logic                    preTrigger;
    logic                    postTrigger;
    logic                    triggered;
    logic                    transition;
    logic                    captureDone;
    logic                    captureAborted;
    logic [2:0]              state;

`ifdef CAPSEQ_FORCE_TRIG_EN
    modport master (
        output start, abort, sampleData, trigMask, trigValue,
               preTriggerSampleCountMax, write_enable, complete, forceTrigger,
        input  idle, preTrigger, postTrigger, triggered, transition,
               captureDone, captureAborted, state
    );
    modport slave (
        input  start, abort, sampleData, trigMask, trigValue,
               preTriggerSampleCountMax, write_enable, complete, forceTrigger,
        output idle, preTrigger, postTrigger, triggered, transition,
               captureDone, captureAborted, state
    );
`else
    modport master (
        output start, abort, sampleData, trigMask, trigValue,
               preTriggerSampleCountMax, write_enable, complete,
        input  idle, preTrigger, postTrigger, triggered, transition,
               captureDone, captureAborted, state
    );
    modport slave (
        input  start, abort, sampleData, trigMask, trigValue,
               preTriggerSampleCountMax, write_enable, complete,
        output idle, preTrigger, postTrigger, triggered, transition,
               captureDone, captureAborted, state
    );
`endif
endinterface

// File: rtl/capture_sequencer.sv
// rtl/capture_sequencer.sv - run-control FSM for one logic-capture run
// Optional: CAPSEQ_FORCE_TRIG_EN adds forceTrigger as an extra trigger source in ARMED.
module capture_sequencer #(
    parameter int SAMPLE_WIDTH = 16
) (
    input  logic                clk,
    input  logic                reset,
    capture_sequencer_if.slave  bus
);
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FILL  = 3'd1,
        S_ARMED = 3'd2,
        S_POST  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t                  state_q, state_d;
    logic [31:0]             fill_count_q, fill_count_d, fill_count_inc;
    logic [SAMPLE_WIDTH-1:0] prev_sample_q;
    logic                    first_sample_q, first_sample_d;
    logic                    capture_done_q, capture_done_d;
    logic                    capture_aborted_q, capture_aborted_d;
    logic                    running;
    logic                    match;
    logic                    force_hit;
    logic                    trig_hit;
    logic                    launch;
    state_t                  launch_state;

    assign running = (state_q == S_FILL) || (state_q == S_ARMED) || (state_q == S_POST);
    assign match   = ((bus.sampleData ^ bus.trigValue) & bus.trigMask) == '0;

`ifdef CAPSEQ_FORCE_TRIG_EN
    assign force_hit = bus.forceTrigger;
`else
    assign force_hit = 1'b0;
`endif

    // Abort wins over a trigger in the same cycle, so no pulse leaks out on abort.
    assign trig_hit     = (state_q == S_ARMED) && (match || force_hit) && !bus.abort;
    assign launch       = bus.start && !bus.abort;
    assign launch_state = (bus.preTriggerSampleCountMax == 32'd0) ? S_ARMED : S_FILL;

    // Saturating count: the fill counter never wraps back under the target.
    assign fill_count_inc = fill_count_q +
        {31'd0, (bus.write_enable && (fill_count_q != 32'hFFFF_FFFF))};

    always_comb begin
        state_d           = state_q;
        fill_count_d      = fill_count_q;
        first_sample_d    = first_sample_q;
        capture_done_d    = capture_done_q;
        capture_aborted_d = capture_aborted_q;

        if (running) begin
            first_sample_d = 1'b0;
        end

        case (state_q)
            S_IDLE, S_DONE: begin
                if (launch) begin
                    state_d           = launch_state;
                    first_sample_d    = 1'b1;
                    fill_count_d      = 32'd0;
                    capture_done_d    = 1'b0;
                    capture_aborted_d = 1'b0;
                end
            end
            S_FILL: begin
                if (bus.abort) begin
                    state_d           = S_DONE;
                    capture_done_d    = 1'b1;
                    capture_aborted_d = 1'b1;
                end else begin
                    fill_count_d = fill_count_inc;
                    if (fill_count_inc == bus.preTriggerSampleCountMax) begin
                        state_d = S_ARMED;
                    end
                end
            end
            S_ARMED: begin
                if (bus.abort) begin
                    state_d           = S_DONE;
                    capture_done_d    = 1'b1;
                    capture_aborted_d = 1'b1;
                end else if (trig_hit) begin
                    state_d = S_POST;
                end
            end
            S_POST: begin
                if (bus.abort) begin
                    state_d           = S_DONE;
                    capture_done_d    = 1'b1;
                    capture_aborted_d = 1'b1;
                end else if (bus.complete) begin
                    state_d        = S_DONE;
                    capture_done_d = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q           <= S_IDLE;
            fill_count_q      <= 32'd0;
            prev_sample_q     <= '0;
            first_sample_q    <= 1'b0;
            capture_done_q    <= 1'b0;
            capture_aborted_q <= 1'b0;
        end else begin
            state_q           <= state_d;
            fill_count_q      <= fill_count_d;
            prev_sample_q     <= bus.sampleData;
            first_sample_q    <= first_sample_d;
            capture_done_q    <= capture_done_d;
            capture_aborted_q <= capture_aborted_d;
        end
    end

    assign bus.idle           = (state_q == S_IDLE);
    assign bus.preTrigger     = (state_q == S_FILL) || (state_q == S_ARMED);
    assign bus.postTrigger    = (state_q == S_POST);
    assign bus.triggered      = trig_hit;
    assign bus.transition     = running && (first_sample_q || (bus.sampleData != prev_sample_q));
    assign bus.captureDone    = capture_done_q;
    assign bus.captureAborted = capture_aborted_q;
    assign bus.state          = state_q;
endmodule

// File: tb/tb_capture_sequencer.sv
// tb/tb_capture_sequencer.sv - scoreboard bench for capture_sequencer
module tb_capture_sequencer;
    logic clk;
    logic reset;

    capture_sequencer_if #(.SAMPLE_WIDTH(16)) bus ();

    capture_sequencer #(.SAMPLE_WIDTH(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        start;
        logic        abort;
        logic        we;
        logic        cmp;
        logic        frc;
        logic [15:0] data;
        logic [9:0]  exp;
        logic [9:0]  care;
    } step_t;

    localparam logic [9:0] C_ALL  = 10'h3FF;
    localparam logic [9:0] C_NOTR = 10'h37F;

    step_t sb[$];
    step_t exp_s;
    int    checks = 0;
    int    errors = 0;

    // {aborted, done, transition, triggered, post, pre, idle, state}
    function automatic logic [9:0] status();
        return {bus.captureAborted, bus.captureDone, bus.transition, bus.triggered,
                bus.postTrigger, bus.preTrigger, bus.idle, bus.state};
    endfunction

    function automatic logic [9:0] ev(input logic [2:0] st, input logic trig, input logic trans,
                                      input logic dn, input logic ab);
        logic idl, pre, post;
        idl  = (st == 3'd0);
        pre  = (st == 3'd1) || (st == 3'd2);
        post = (st == 3'd3);
        return {ab, dn, trans, trig, post, pre, idl, st};
    endfunction

    function automatic step_t sp(input logic rst, input logic start, input logic abort,
                                 input logic we, input logic cmp, input logic frc,
                                 input logic [15:0] d, input logic [9:0] e, input logic [9:0] c);
        step_t s;
        s.rst = rst; s.start = start; s.abort = abort; s.we = we;
        s.cmp = cmp; s.frc = frc; s.data = d; s.exp = e; s.care = c;
        return s;
    endfunction

    task automatic apply(input step_t s);
        reset            = s.rst;
        bus.start        = s.start;
        bus.abort        = s.abort;
        bus.write_enable = s.we;
        bus.complete     = s.cmp;
        bus.sampleData   = s.data;
`ifdef CAPSEQ_FORCE_TRIG_EN
        bus.forceTrigger = s.frc;
`endif
    endtask

    task automatic test_reset();
        step_t tbl[$];
        apply(sp(1, 0, 0, 0, 0, 0, 16'h0, 10'h0, 10'h0));
        bus.trigMask = 16'h0; bus.trigValue = 16'h0; bus.preTriggerSampleCountMax = 32'd0;
        repeat (3) @(negedge clk);
        tbl.push_back(sp(1, 0, 0, 0, 0, 0, 16'h0, ev(0, 0, 0, 0, 0), C_ALL));
        tbl.push_back(sp(0, 0, 0, 0, 0, 0, 16'h0, ev(0, 0, 0, 0, 0), C_ALL));
        foreach (tbl[i]) begin
            apply(tbl[i]); sb.push_back(tbl[i]); #1;
            exp_s = sb.pop_front(); checks++;
            if ((status() & exp_s.care) !== (exp_s.exp & exp_s.care)) begin
                errors++;
                $display("FAIL reset[%0d] got %h want %h", i, status() & exp_s.care, exp_s.exp & exp_s.care);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_pretrigger_fill();
        step_t tbl[$];
        bus.preTriggerSampleCountMax = 32'd4; bus.trigMask = 16'h0001; bus.trigValue = 16'h0001;
        tbl.push_back(sp(0, 1, 0, 0, 0, 0, 16'h0, ev(0, 0, 0, 0, 0), C_ALL));
        tbl.push_back(sp(0, 0, 0, 1, 0, 0, 16'h0, ev(1, 0, 0, 0, 0), C_NOTR));
        tbl.push_back(sp(0, 0, 0, 1, 0, 0, 16'h0, ev(1, 0, 0, 0, 0), C_NOTR));
        tbl.push_back(sp(0, 0, 0, 0, 0, 0, 16'h1, ev(1, 0, 0, 0, 0), C_NOTR));
        tbl.push_back(sp(0, 0, 0, 1, 0, 0, 16'h1, ev(1, 0, 0, 0, 0), C_NOTR));
        tbl.push_back(sp(0, 0, 0, 1, 0, 0, 16'h1, ev(1, 0, 0, 0, 0), C_NOTR));
        tbl.push_back(sp(0, 0, 0, 0, 0, 0, 16'h1, ev(2, 1, 0, 0, 0), C_NOTR));
        tbl.push_back(sp(0, 0, 0, 0, 0, 0, 16'h1, ev(3, 0, 0, 0, 0), C_NOTR));
        tbl.push_back(sp(0, 0, 0, 0, 1, 0, 16'h1, ev(3, 0, 0, 0, 0), C_NOTR));
        tbl.push_back(sp(0, 0, 0, 0, 0, 0, 16'h1, ev(4, 0, 0, 1, 0), C_ALL));
        foreach (tbl[i]) begin
            apply(tbl[i]); sb.push_back(tbl[i]); #1;
            exp_s = sb.pop_front(); checks++;
            if ((status() & exp_s.care) !== (exp_s.exp & exp_s.care)) begin
                errors++;
                $display("FAIL fill[%0d] got %h want %h", i, status() & exp_s.care, exp_s.exp & exp_s.care);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_zero_depth();
        step_t tbl[$];
        bus.preTriggerSampleCountMax = 32'd0; bus.trigMask = 16'h0; bus.trigValue = 16'h0;
        tbl.push_back(sp(0, 1, 0, 0, 0, 0, 16'h0, ev(4, 0, 0, 1, 0), C_ALL));
        tbl.push_back(sp(0, 0, 0, 0, 0, 0, 16'h0, ev(2, 1, 0, 0, 0), C_NOTR));
        tbl.push_back(sp(0, 0, 0, 0, 0, 0, 16'h0, ev(3, 0, 0, 0, 0), C_NOTR));
        tbl.push_back(sp(0, 0, 0, 0, 1, 0, 16'h0, ev(3, 0, 0, 0, 0), C_NOTR));
        tbl.push_back(sp(0, 0, 0, 0, 0, 0, 16'h0, ev(4, 0, 0, 1, 0), C_ALL));
        foreach (tbl[i]) begin
            apply(tbl[i]); sb.push_back(tbl[i]); #1;
            exp_s = sb.pop_front(); checks++;
            if ((status() & exp_s.care) !== (exp_s.exp & exp_s.care)) begin
                errors++;
                $display("FAIL zero_depth[%0d] got %h want %h", i, status() & exp_s.care, exp_s.exp & exp_s.care);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_abort_complete_post();
        step_t tbl[$];
        bus.preTriggerSampleCountMax = 32'd0; bus.trigMask = 16'h0;
        tbl.push_back(sp(0, 1, 0, 0, 0, 0, 16'h0, ev(4, 0, 0, 1, 0), C_ALL));
        tbl.push_back(sp(0, 0, 0, 0, 0, 0, 16'h0, ev(2, 1, 0, 0, 0), C_NOTR));
        tbl.push_back(sp(0, 0, 0, 0, 0, 0, 16'h0, ev(3, 0, 0, 0, 0), C_NOTR));
        tbl.push_back(sp(0, 0, 1, 0, 1, 0, 16'h0, ev(3, 0, 0, 0, 0), C_NOTR));
        tbl.push_back(sp(0, 0, 0, 0, 0, 0, 16'h0, ev(4, 0, 0, 1, 1), C_ALL));
        foreach (tbl[i]) begin
            apply(tbl[i]); sb.push_back(tbl[i]); #1;
            exp_s = sb.pop_front(); checks++;
            if ((status() & exp_s.care) !== (exp_s.exp & exp_s.care)) begin
                errors++;
                $display("FAIL abort_post[%0d] got %h want %h", i, status() & exp_s.care, exp_s.exp & exp_s.care);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_abort_match_armed();
        step_t tbl[$];
        bus.preTriggerSampleCountMax = 32'd2; bus.trigMask = 16'h0;
        tbl.push_back(sp(0, 1, 0, 0, 0, 0, 16'h0, ev(4, 0, 0, 1, 1), C_ALL));
        tbl.push_back(sp(0, 0, 0, 1, 0, 0, 16'h0, ev(1, 0, 0, 0, 0), C_NOTR));
        tbl.push_back(sp(0, 0, 0, 1, 0, 0, 16'h0, ev(1, 0, 0, 0, 0), C_NOTR));
        tbl.push_back(sp(0, 0, 1, 0, 0, 0, 16'h0, ev(2, 0, 0, 0, 0), C_NOTR));
        tbl.push_back(sp(0, 1, 0, 0, 0, 0, 16'h0, ev(4, 0, 0, 1, 1), C_ALL));
        tbl.push_back(sp(0, 0, 1, 0, 0, 0, 16'h0, ev(1, 0, 0, 0, 0), C_NOTR));
        tbl.push_back(sp(0, 0, 0, 0, 0, 0, 16'h0, ev(4, 0, 0, 1, 1), C_ALL));
        foreach (tbl[i]) begin
            apply(tbl[i]); sb.push_back(tbl[i]); #1;
            exp_s = sb.pop_front(); checks++;
            if ((status() & exp_s.care) !== (exp_s.exp & exp_s.care)) begin
                errors++;
                $display("FAIL abort_armed[%0d] got %h want %h", i, status() & exp_s.care, exp_s.exp & exp_s.care);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_transition();
        step_t tbl[$];
        bus.preTriggerSampleCountMax = 32'd100; bus.trigMask = 16'h0;
        tbl.push_back(sp(0, 1, 0, 0, 0, 0, 16'h00A5, ev(4, 0, 0, 1, 1), C_ALL));
        tbl.push_back(sp(0, 0, 0, 0, 0, 0, 16'h00A5, ev(1, 0, 1, 0, 0), C_ALL));
        tbl.push_back(sp(0, 0, 0, 0, 0, 0, 16'h00A5, ev(1, 0, 0, 0, 0), C_ALL));
        tbl.push_back(sp(0, 0, 0, 0, 0, 0, 16'h00A5, ev(1, 0, 0, 0, 0), C_ALL));
        tbl.push_back(sp(0, 0, 0, 0, 0, 0, 16'h00A4, ev(1, 0, 1, 0, 0), C_ALL));
        tbl.push_back(sp(0, 0, 0, 0, 0, 0, 16'h00A4, ev(1, 0, 0, 0, 0), C_ALL));
        tbl.push_back(sp(0, 0, 1, 0, 0, 0, 16'h00A4, ev(1, 0, 0, 0, 0), C_ALL));
        tbl.push_back(sp(0, 0, 0, 0, 0, 0, 16'h0000, ev(4, 0, 0, 1, 1), C_ALL));
        foreach (tbl[i]) begin
            apply(tbl[i]); sb.push_back(tbl[i]); #1;
            exp_s = sb.pop_front(); checks++;
            if ((status() & exp_s.care) !== (exp_s.exp & exp_s.care)) begin
                errors++;
                $display("FAIL transition[%0d] got %h want %h", i, status() & exp_s.care, exp_s.exp & exp_s.care);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_midrun();
        step_t tbl[$];
        bus.preTriggerSampleCountMax = 32'd100; bus.trigMask = 16'h0;
        tbl.push_back(sp(0, 1, 0, 0, 0, 0, 16'h0, ev(4, 0, 0, 1, 1), C_ALL));
        tbl.push_back(sp(1, 0, 0, 0, 0, 0, 16'h0, ev(1, 0, 0, 0, 0), C_NOTR));
        tbl.push_back(sp(0, 0, 1, 0, 0, 0, 16'h0, ev(0, 0, 0, 0, 0), C_ALL));
        tbl.push_back(sp(0, 1, 1, 0, 0, 0, 16'h0, ev(0, 0, 0, 0, 0), C_ALL));
        tbl.push_back(sp(0, 0, 0, 0, 0, 0, 16'h0, ev(0, 0, 0, 0, 0), C_ALL));
        foreach (tbl[i]) begin
            apply(tbl[i]); sb.push_back(tbl[i]); #1;
            exp_s = sb.pop_front(); checks++;
            if ((status() & exp_s.care) !== (exp_s.exp & exp_s.care)) begin
                errors++;
                $display("FAIL reset_midrun[%0d] got %h want %h", i, status() & exp_s.care, exp_s.exp & exp_s.care);
            end
            @(negedge clk);
        end
    endtask

`ifdef CAPSEQ_FORCE_TRIG_EN
    task automatic test_force_armed();
        step_t tbl[$];
        bus.preTriggerSampleCountMax = 32'd0; bus.trigMask = 16'hFFFF; bus.trigValue = 16'hFFFF;
        tbl.push_back(sp(0, 1, 0, 0, 0, 0, 16'h0, ev(0, 0, 0, 0, 0), C_ALL));
        tbl.push_back(sp(0, 0, 0, 0, 0, 0, 16'h0, ev(2, 0, 0, 0, 0), C_NOTR));
        tbl.push_back(sp(0, 0, 0, 0, 0, 1, 16'h0, ev(2, 1, 0, 0, 0), C_NOTR));
        tbl.push_back(sp(0, 0, 0, 0, 0, 0, 16'h0, ev(3, 0, 0, 0, 0), C_NOTR));
        tbl.push_back(sp(0, 0, 1, 0, 0, 0, 16'h0, ev(3, 0, 0, 0, 0), C_NOTR));
        tbl.push_back(sp(0, 0, 0, 0, 0, 0, 16'h0, ev(4, 0, 0, 1, 1), C_ALL));
        foreach (tbl[i]) begin
            apply(tbl[i]); sb.push_back(tbl[i]); #1;
            exp_s = sb.pop_front(); checks++;
            if ((status() & exp_s.care) !== (exp_s.exp & exp_s.care)) begin
                errors++;
                $display("FAIL force_armed[%0d] got %h want %h", i, status() & exp_s.care, exp_s.exp & exp_s.care);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_force_fill();
        step_t tbl[$];
        bus.preTriggerSampleCountMax = 32'd1; bus.trigMask = 16'hFFFF; bus.trigValue = 16'hFFFF;
        tbl.push_back(sp(0, 1, 0, 0, 0, 0, 16'h0, ev(4, 0, 0, 1, 1), C_ALL));
        tbl.push_back(sp(0, 0, 0, 0, 0, 1, 16'h0, ev(1, 0, 0, 0, 0), C_NOTR));
        tbl.push_back(sp(0, 0, 0, 0, 0, 1, 16'h0, ev(1, 0, 0, 0, 0), C_NOTR));
        tbl.push_back(sp(0, 0, 0, 1, 0, 0, 16'h0, ev(1, 0, 0, 0, 0), C_NOTR));
        tbl.push_back(sp(0, 0, 0, 0, 0, 0, 16'h0, ev(2, 0, 0, 0, 0), C_NOTR));
        tbl.push_back(sp(0, 0, 1, 0, 0, 0, 16'h0, ev(2, 0, 0, 0, 0), C_NOTR));
        tbl.push_back(sp(0, 0, 0, 0, 0, 0, 16'h0, ev(4, 0, 0, 1, 1), C_ALL));
        foreach (tbl[i]) begin
            apply(tbl[i]); sb.push_back(tbl[i]); #1;
            exp_s = sb.pop_front(); checks++;
            if ((status() & exp_s.care) !== (exp_s.exp & exp_s.care)) begin
                errors++;
                $display("FAIL force_fill[%0d] got %h want %h", i, status() & exp_s.care, exp_s.exp & exp_s.care);
            end
            @(negedge clk);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_pretrigger_fill();
        test_zero_depth();
        test_abort_complete_post();
        test_abort_match_armed();
        test_transition();
        test_reset_midrun();
`ifdef CAPSEQ_FORCE_TRIG_EN
        test_force_armed();
        test_force_fill();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
